// File: rtl/scan_pkg.sv
// Shared types and CUT-matched defaults for the scan-test controller.
package scan_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int N_OUT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    SETTLE,
    CAPTURE,
    SHIFT_OUT
  } state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Width-parameterised shift register: parallel load, MSB-first serial shift (W >= 2).
module scan_shift_reg #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_ld_data,
  input  logic         i_shift,
  input  logic         i_sin,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_q <= '0;
    else if (i_load)  r_q <= i_ld_data;
    else if (i_shift) r_q <= {r_q[W-2:0], i_sin};
  end

  assign o_q = r_q;

endmodule

// File: rtl/scan_test_controller.sv
// Scan-test front end: shift pattern in, settle, capture CUT response, shift it out.
// Build option SCAN_UPDATE_LATCH_EN: cut_in comes from an update register loaded once per pattern.
module scan_test_controller
  import scan_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int N_OUT      = N_OUT_DEF,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pat_valid,
  input  logic [N_IN-1:0]  i_pat_data,
  output logic             o_pat_ready,
  output logic [N_IN-1:0]  o_cut_in,
  input  logic [N_OUT-1:0] i_cut_out,
  output logic             o_so,
  output logic             o_so_valid,
  output logic             o_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_pat_cnt
);

  localparam int CW = $clog2(N_IN + N_OUT + 16);

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [N_IN-1:0]  r_pat, w_chain;
  logic [N_OUT-1:0] w_resp;
  logic             r_pat_ready, r_done;
  logic [CNT_W-1:0] r_pat_cnt;
  logic             w_accept, w_shift_in, w_capture, w_shift_out, w_finish;
  logic             w_unused_bits;

  assign w_accept = i_pat_valid && r_pat_ready;
  assign w_finish = (r_state == SHIFT_OUT) && (w_next == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_next = SHIFT_IN;
      SHIFT_IN:  if (r_cnt == CW'(N_IN - 1)) w_next = SETTLE;
      SETTLE:    if (r_cnt == '0) w_next = CAPTURE;
      CAPTURE:   w_next = SHIFT_OUT;
      SHIFT_OUT: if (r_cnt == CW'(N_OUT - 1)) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_shift_in  = (r_state == SHIFT_IN);
    w_capture   = (r_state == CAPTURE);
    w_shift_out = (r_state == SHIFT_OUT);
    o_busy      = (r_state != IDLE);
  end

  // r_cnt: up-count in SHIFT_IN/SHIFT_OUT, down-count in SETTLE, reloaded on every state change.
  // r_pat is consumed MSB-first as it feeds the chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_pat       <= '0;
      r_pat_ready <= 1'b1;
      r_done      <= 1'b0;
      r_pat_cnt   <= '0;
    end else begin
      r_pat_ready <= (w_next == IDLE);
      r_done      <= w_finish;
      if (w_finish) r_pat_cnt <= r_pat_cnt + CNT_W'(1);
      if (w_accept)        r_pat <= i_pat_data;
      else if (w_shift_in) r_pat <= r_pat << 1;
      if (w_next != r_state)      r_cnt <= (w_next == SETTLE) ? CW'(SETTLE_CYC - 1) : '0;
      else if (r_state == SETTLE) r_cnt <= r_cnt - CW'(1);
      else if (r_state != IDLE)   r_cnt <= r_cnt + CW'(1);
    end
  end

  scan_shift_reg #(.W(N_IN)) u_chain (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (1'b0),
    .i_ld_data ('0),
    .i_shift   (w_shift_in),
    .i_sin     (r_pat[N_IN-1]),
    .o_q       (w_chain)
  );

  scan_shift_reg #(.W(N_OUT)) u_resp (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_capture),
    .i_ld_data (i_cut_out),
    .i_shift   (w_shift_out),
    .i_sin     (1'b0),
    .o_q       (w_resp)
  );

`ifdef SCAN_UPDATE_LATCH_EN
  // Loads the post-final-shift chain value so cut_in changes exactly once per pattern.
  logic [N_IN-1:0] r_upd;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_upd <= '0;
    else if (w_shift_in && (w_next == SETTLE)) r_upd <= {w_chain[N_IN-2:0], r_pat[N_IN-1]};
  end
  assign o_cut_in      = r_upd;
  assign w_unused_bits = ^{w_resp[N_OUT-2:0], w_chain[N_IN-1]};
`else
  assign o_cut_in      = w_chain;
  assign w_unused_bits = ^w_resp[N_OUT-2:0];
`endif

  assign o_pat_ready = r_pat_ready;
  assign o_so_valid  = w_shift_out;
  assign o_so        = w_shift_out & w_resp[N_OUT-1];
  assign o_done      = r_done;
  assign o_pat_cnt   = r_pat_cnt;

endmodule
